// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg
// Shared definitions for the pipeline hazard controller:
//   hz_state_e - sequencing state (normal run / waiting on data memory)
//   PCSEL_*    - encodings of the PC next-address select
//   REG_ZERO   - architectural register $zero, which never carries a dependency
package hazard_controller_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_e;

   localparam logic PCSEL_SEQ = 1'b0;
   localparam logic PCSEL_BR  = 1'b1;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter
// Saturating event counter: increments on each enabled cycle, sticks at all-ones.
// Ports:
//   clk, reset (sync, active-high) - clock and counter clear
//   enable                         - count this cycle
//   count [CNT_W]                  - current count
module hazard_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (enable)
         count <= sat_inc(count);
   end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline sequencing controller for the five-stage MIPS pipeline. Decides each
// cycle whether PC and the inter-stage registers advance, freeze or flush, and
// selects the next PC source. Handles multi-cycle data-memory waits (with a
// timeout), branches resolved taken in EX, and load-use hazards, in that
// priority order. All control outputs are combinational from state and inputs.
// Ports:
//   clk, reset                     - clock, sync active-high reset
//   id_rs, id_rt, id_uses_rt       - source operands of the instruction in ID
//   ex_mem_read, ex_rt             - load in EX and its destination register
//   ex_branch_taken                - branch/jump in EX resolved taken
//   mem_req, mem_ready             - data-memory access in MEM and its completion
//   pc_freeze, ifid_freeze         - hold PC / IF/ID
//   ifid_flush, idex_flush         - load NOP into IF/ID / ID/EX
//   exmem_freeze                   - hold ID/EX and EX/MEM
//   memwb_flush                    - load NOP into MEM/WB
//   pc_sel                         - PCSEL_SEQ (PC+4) or PCSEL_BR (branch target)
//   mem_error                      - sticky memory-timeout flag
//   stall_cycles, flush_events     - saturating performance counters
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_freeze,
   output logic             ifid_freeze,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_freeze,
   output logic             memwb_flush,
   output logic             pc_sel,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int            TW        = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TCNT_LAST = TW'(MEM_TIMEOUT - 1);

   hz_state_e      state_q, state_nx;
   logic [TW-1:0]  tcnt_q, tcnt_nx;
   logic           stall_raw;
   logic           timeout;
   logic           mem_stall;
   logic           branch_act;
   logic           load_use;

   // State, timeout counter and sticky error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RUN;
         tcnt_q    <= '0;
         mem_error <= 1'b0;
      end else begin
         state_q <= state_nx;
         tcnt_q  <= tcnt_nx;
         if (timeout)
            mem_error <= 1'b1;
      end
   end

   // Hazard resolution and next state
   always_comb begin
      stall_raw    = 1'b0;
      timeout      = 1'b0;
      mem_stall    = 1'b0;
      branch_act   = 1'b0;
      load_use     = 1'b0;
      state_nx     = RUN;
      tcnt_nx      = '0;
      pc_freeze    = 1'b0;
      ifid_freeze  = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_freeze = 1'b0;
      memwb_flush  = 1'b0;
      pc_sel       = PCSEL_SEQ;

      // Once an access has timed out the memory is treated as unreliable and
      // its wait requests are no longer honoured.
      stall_raw = mem_req && !mem_ready && !mem_error;
      // The last permitted wait cycle forces a release instead of freezing again.
      timeout   = stall_raw && (state_q == MEM_WAIT) && (tcnt_q == TCNT_LAST);
      mem_stall = stall_raw && !timeout;

      // A taken branch discards the ID instruction, so its hazard is moot.
      branch_act = !mem_stall && ex_branch_taken;
      load_use   = !mem_stall && !ex_branch_taken && ex_mem_read &&
                   (ex_rt != REG_ZERO) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

      if (mem_stall) begin
         state_nx = MEM_WAIT;
         // Entry cycle leaves the counter at zero; each further wait cycle counts.
         if (state_q == MEM_WAIT)
            tcnt_nx = tcnt_q + TW'(1);
      end

      pc_freeze    = mem_stall || load_use;
      ifid_freeze  = mem_stall || load_use;
      exmem_freeze = mem_stall;
      memwb_flush  = mem_stall;
      ifid_flush   = branch_act;
      idex_flush   = branch_act || load_use;
      pc_sel       = branch_act ? PCSEL_BR : PCSEL_SEQ;
   end

   hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk    (clk),
      .reset  (reset),
      .enable (pc_freeze),
      .count  (stall_cycles)
   );

   hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk    (clk),
      .reset  (reset),
      .enable (branch_act),
      .count  (flush_events)
   );

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

   localparam int TO   = 4;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    id_rs, id_rt, ex_rt;
   logic          id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
   logic          pc_freeze, ifid_freeze, ifid_flush, idex_flush;
   logic          exmem_freeze, memwb_flush, pc_sel, mem_error;
   logic [CW-1:0] stall_cycles, flush_events;

   always #5 clk = ~clk;

   hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .ex_mem_read     (ex_mem_read),
      .ex_rt           (ex_rt),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_freeze       (pc_freeze),
      .ifid_freeze     (ifid_freeze),
      .ifid_flush      (ifid_flush),
      .idex_flush      (idex_flush),
      .exmem_freeze    (exmem_freeze),
      .memwb_flush     (memwb_flush),
      .pc_sel          (pc_sel),
      .mem_error       (mem_error),
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: error flag, length of the current run of memory-frozen
   // cycles, and event totals.
   bit m_err;
   int m_frozen;
   int m_stall;
   int m_flush;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input bit req, input bit rdy, input bit br, input bit rd,
                        input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input bit urt);
      mem_req = req; mem_ready = rdy; ex_branch_taken = br; ex_mem_read = rd;
      ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt;
   endtask

   task automatic model_clear();
      m_err = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   // Compare one cycle's outputs against the model, then advance one clock.
   task automatic cycle();
      bit sreq, tmo, fm, bra, lu, frz;
      #3;
      sreq = mem_req && !mem_ready && !m_err;
      tmo  = sreq && (m_frozen == TO);
      fm   = sreq && !tmo;
      bra  = !fm && ex_branch_taken;
      lu   = !fm && !ex_branch_taken && ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      frz  = fm || lu;
      check("pc_freeze",    32'(pc_freeze),    32'(frz));
      check("ifid_freeze",  32'(ifid_freeze),  32'(frz));
      check("ifid_flush",   32'(ifid_flush),   32'(bra));
      check("idex_flush",   32'(idex_flush),   32'(bra || lu));
      check("exmem_freeze", 32'(exmem_freeze), 32'(fm));
      check("memwb_flush",  32'(memwb_flush),  32'(fm));
      check("pc_sel",       32'(pc_sel),       32'(bra));
      check("mem_error",    32'(mem_error),    32'(m_err));
      check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      check("flush_events", 32'(flush_events), 32'(m_flush));
      m_frozen = fm ? m_frozen + 1 : 0;
      if (tmo) m_err = 1;
      if (frz && m_stall < CMAX) m_stall++;
      if (bra && m_flush < CMAX) m_flush++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      model_clear();
      do_reset();

      // Reset state
      idle(); cycle();

      // Load-use on rs for one cycle, then a clean cycle
      do_reset();
      drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd9, 0); cycle();
      idle(); cycle();
      check("lu_stall_cnt", 32'(stall_cycles), 32'd1);

      // $zero and id_uses_rt gating: no stall expected
      do_reset();
      drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd3, 1); cycle();
      drive(0, 0, 0, 1, 5'd7, 5'd2, 5'd7, 0); cycle();
      drive(0, 0, 0, 1, 5'd7, 5'd2, 5'd7, 1); cycle();
      idle(); cycle();

      // Branch coinciding with a load-use hazard
      do_reset();
      drive(0, 0, 1, 1, 5'd5, 5'd5, 5'd5, 1); cycle();
      idle(); cycle();
      check("br_flush_cnt", 32'(flush_events), 32'd1);
      check("br_stall_cnt", 32'(stall_cycles), 32'd0);

      // Memory wait of 3 cycles with a pending branch, released with ready
      do_reset();
      repeat (3) begin drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0); cycle(); end
      drive(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0); cycle();
      idle(); cycle();
      check("mw_stall_cnt", 32'(stall_cycles), 32'd3);
      check("mw_flush_cnt", 32'(flush_events), 32'd1);

      // Timeout: ready never comes
      do_reset();
      repeat (TO + 1) begin drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0); cycle(); end
      check("to_err", 32'(mem_error), 32'd1);
      drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0); cycle();
      check("to_nostall", 32'(pc_freeze), 32'd0);
      idle(); cycle();

      // Reset in the middle of a memory wait
      do_reset();
      repeat (2) begin drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0); cycle(); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
      idle(); cycle();
      drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0); cycle();
      idle(); cycle();

      // Counter saturation: 5 load-use cycles on a 2-bit counter
      do_reset();
      repeat (5) begin drive(0, 0, 0, 1, 5'd4, 5'd1, 5'd4, 1); cycle(); end
      idle(); cycle();
      check("sat_stall_cnt", 32'(stall_cycles), 32'd3);

      // Randomized traffic with small register indices to provoke matches
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            drive($urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) < 5,
                  $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 5,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1);
            cycle();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the five-stage MIPS pipeline. Each cycle it decides whether the program counter and the IF/ID, ID/EX and EX/MEM pipeline registers advance, freeze or flush, and what the PC next-address select is. It covers load-use hazards, branches taken in EX, and multi-cycle data-memory accesses with a timeout. It drives the PC register's freeze input and the freeze/flush inputs of the inter-stage registers.

## Interface
- MEM_TIMEOUT, 64: maximum MEM_WAIT cycles before the access is abandoned and an error is flagged (≥2).
- CNT_W, 16: width of the saturating performance counters.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination rt of the load in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- mem_req  in  1  instruction in MEM is accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_freeze  out  1  hold PC
- ifid_freeze  out  1  hold IF/ID
- ifid_flush  out  1  load NOP into IF/ID
- idex_flush  out  1  load NOP (bubble) into ID/EX
- exmem_freeze  out  1  hold ID/EX and EX/MEM
- memwb_flush  out  1  load NOP into MEM/WB
- pc_sel  out  1  0 = PC+4, 1 = branch target from EX
- mem_error  out  1  sticky timeout flag
- stall_cycles  out  CNT_W  cycles with pc_freeze=1, saturating
- flush_events  out  CNT_W  cycles with ex_branch_taken acted on, saturating

## Operation
- States: RUN, MEM_WAIT. Reset → RUN. Timeout counter = 0. mem_error = 0. Both perf counters = 0.
- Outputs are combinational from the state and the current inputs. State, counters and mem_error are registered.
- Priority when conditions coincide: memory stall > branch flush > load-use stall.
- Memory stall:
  - Condition: mem_req=1 and mem_ready=0 (in RUN or MEM_WAIT), and mem_error not being set this cycle.
  - Action: pc_freeze, ifid_freeze, exmem_freeze = 1; memwb_flush = 1.
  - ex_branch_taken and load-use are ignored. The EX instruction is frozen and gets re-evaluated on release.
  - RUN → MEM_WAIT. In MEM_WAIT the timeout counter increments each cycle.
- Release:
  - mem_ready=1 in MEM_WAIT → RUN and clear the counter.
  - Branch and load-use evaluation resumes in that same cycle.
- Timeout:
  - Trigger: in MEM_WAIT with the counter equal to MEM_TIMEOUT-1 and mem_ready=0.
  - Action: set mem_error, return to RUN, clear the counter. The freeze outputs are deasserted in that cycle (forced release).
  - mem_error stays set until reset. While mem_error=1, MEM_WAIT is never entered again and the memory stall is ignored.
- Branch flush (no memory stall, ex_branch_taken=1):
  - pc_sel = 1, ifid_flush = 1, idex_flush = 1.
  - The load-use check is suppressed because the ID instruction is being discarded.
- Load-use (no memory stall, no branch):
  - Condition: ex_mem_read=1, ex_rt≠0, and either ex_rt==id_rs, or ex_rt==id_rt with id_uses_rt=1.
  - Action: pc_freeze = 1, ifid_freeze = 1, idex_flush = 1.
- Otherwise all control outputs are 0 and pc_sel = 0.
- Counters saturate at all-ones and never wrap.

## Timing
- Zero-latency control: hazard outputs react in the same cycle as the inputs.
- Load-use costs exactly 1 bubble cycle. Branch costs 2 discarded instructions, flushed in the one cycle.
- Memory stall lasts N cycles, where N is the number of cycles mem_ready stays low, capped at MEM_TIMEOUT.
- mem_error rises on the clock edge that ends the timeout cycle.
- Reset mid-MEM_WAIT returns to RUN on the next edge; all outputs read 0 in the cycle after reset.
- mem_req and mem_ready both high in the same cycle: no stall, state stays or returns RUN.

## Structure
- Shared package holds:
  - the state enum (RUN, MEM_WAIT);
  - the pc_sel encodings PCSEL_SEQ=0 and PCSEL_BR=1;
  - the register-zero constant.
- One sub-module, hazard_sat_counter (CNT_W, enable, reset), instantiated twice for stall_cycles and flush_events.
- The FSM, timeout counter and comparator logic stay in hazard_controller.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle → pc_freeze=ifid_freeze=idex_flush=1 for that cycle only; stall_cycles=1.
- Register zero and id_uses_rt:
  - ex_rt=0 matching id_rs → no stall.
  - ex_rt=7 = id_rt with id_uses_rt=0 → no stall.
- Branch with simultaneous load-use: ex_branch_taken=1 → pc_sel=1, ifid_flush=idex_flush=1, pc_freeze=0; flush_events increments.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, plus ex_branch_taken=1 during that time:
  - → 3 frozen cycles, pc_sel=0 throughout;
  - branch is acted on in the release cycle;
  - stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_ready never asserted:
  - → 4 frozen cycles, then mem_error=1 and freeze=0;
  - a later mem_req with mem_ready=0 causes no stall.
- Reset during MEM_WAIT → next cycle state RUN, all outputs 0, counters 0. Saturation check with CNT_W=2: 5 stall cycles → stall_cycles=3.
